// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use bubbles, redirect flushes, memory freeze.
// Optional perf counters are built when HAZ_PERF_EN is defined; otherwise stall_cnt/flush_cnt read 0.
module hazard_ctrl #(
    parameter int LOAD_LAT    = 1,
    parameter int FLUSH_SLOTS = 1,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset_0,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic             use_rs_id,
    input  logic             use_rt_id,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             redirect_id,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    if (LOAD_LAT < 1 || LOAD_LAT > 7) begin : g_bad_load_lat
        $error("hazard_ctrl: LOAD_LAT must be 1..7");
    end
    if (FLUSH_SLOTS < 1 || FLUSH_SLOTS > 3) begin : g_bad_flush_slots
        $error("hazard_ctrl: FLUSH_SLOTS must be 1..3");
    end

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LU_STALL,
        ST_REDIRECT
    } state_t;

    localparam logic [2:0] LU_INIT = 3'(LOAD_LAT - 1);
    localparam logic [2:0] FL_INIT = 3'(FLUSH_SLOTS - 1);

    state_t     state;
    logic [2:0] cnt;
    logic       lu_hit;
    logic       do_stall;
    logic       do_flush;

    assign lu_hit = ex_memread && (ex_rd != 5'd0) &&
                    ((use_rs_id && (rs_id == ex_rd)) || (use_rt_id && (rt_id == ex_rd)));

    // A redirect seen in ID while a load-use hit is pending is dropped: its operands are stale.
    assign do_stall = !mem_busy && ((state == ST_LU_STALL) || ((state == ST_RUN) && lu_hit));
    assign do_flush = !mem_busy && ((state == ST_REDIRECT) ||
                                    ((state == ST_RUN) && !lu_hit && redirect_id));

    // NOTE: every output gets a default before any branch so always_comb cannot infer a latch.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        if (mem_busy) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            pipe_freeze = 1'b1;
        end else if (do_stall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end else if (do_flush) begin
            ifid_flush  = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset_0) begin
        if (reset_0) begin
            state <= ST_RUN;
            cnt   <= 3'd0;
        end else if (!mem_busy) begin
            case (state)
                ST_RUN: begin
                    if (lu_hit) begin
                        if (LOAD_LAT > 1) begin
                            state <= ST_LU_STALL;
                            cnt   <= LU_INIT;
                        end
                    end else if (redirect_id) begin
                        if (FLUSH_SLOTS > 1) begin
                            state <= ST_REDIRECT;
                            cnt   <= FL_INIT;
                        end
                    end
                end
                ST_LU_STALL, ST_REDIRECT: begin
                    if (cnt == 3'd1) begin
                        state <= ST_RUN;
                        cnt   <= 3'd0;
                    end else begin
                        cnt   <= cnt - 3'd1;
                    end
                end
                default: begin
                    state <= ST_RUN;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

`ifdef HAZ_PERF_EN
    always_ff @(posedge clock or posedge reset_0) begin
        if (reset_0) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (idex_bubble) stall_cnt <= stall_cnt + 1'b1;
            if (ifid_flush)  flush_cnt <= flush_cnt + 1'b1;
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (LOAD_LAT=1/FLUSH_SLOTS=1 and LOAD_LAT=3/FLUSH_SLOTS=2)
// share one stimulus stream; a behavioural model predicts each cycle's outputs.
module tb_hazard_ctrl;

    localparam int CNT_W = 32;

    logic             clock = 1'b0;
    logic             reset_0;
    logic [4:0]       rs_id, rt_id, ex_rd;
    logic             use_rs_id, use_rt_id, ex_memread, redirect_id, mem_busy;

    logic             a_pc_en, a_ifid_en, a_ifid_flush, a_idex_bubble, a_pipe_freeze;
    logic             b_pc_en, b_ifid_en, b_ifid_flush, b_idex_bubble, b_pipe_freeze;
    logic [CNT_W-1:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;

    always #5 clock = ~clock;

    hazard_ctrl #(.LOAD_LAT(1), .FLUSH_SLOTS(1), .CNT_W(CNT_W)) dut_a (
        .clock(clock), .reset_0(reset_0), .rs_id(rs_id), .rt_id(rt_id),
        .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .redirect_id(redirect_id), .mem_busy(mem_busy), .pc_en(a_pc_en), .ifid_en(a_ifid_en),
        .ifid_flush(a_ifid_flush), .idex_bubble(a_idex_bubble), .pipe_freeze(a_pipe_freeze),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    hazard_ctrl #(.LOAD_LAT(3), .FLUSH_SLOTS(2), .CNT_W(CNT_W)) dut_b (
        .clock(clock), .reset_0(reset_0), .rs_id(rs_id), .rt_id(rt_id),
        .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .redirect_id(redirect_id), .mem_busy(mem_busy), .pc_en(b_pc_en), .ifid_en(b_ifid_en),
        .ifid_flush(b_ifid_flush), .idex_bubble(b_idex_bubble), .pipe_freeze(b_pipe_freeze),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_bubble;
        logic pipe_freeze;
    } outs_t;

    typedef struct {
        int mode;      // 0 run, 1 load-use stall, 2 redirect flush
        int left;
        int stall_c;
        int flush_c;
    } mdl_t;

    typedef struct {
        string tag;
        outs_t a_o;
        outs_t b_o;
        int    a_s, a_f, b_s, b_f;
    } exp_t;

    exp_t sb[$];
    mdl_t ma, mb;
    int   errors = 0;
    int   checks = 0;
    int   a_bubbles, b_bubbles, b_flushes;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int perf(input int v);
`ifdef HAZ_PERF_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    function automatic outs_t model_step(inout mdl_t m, input int load_lat, input int flush_slots);
        outs_t o;
        bit    hit;
        hit = ex_memread && (ex_rd != 0) &&
              ((use_rs_id && rs_id == ex_rd) || (use_rt_id && rt_id == ex_rd));
        if (reset_0) m = '{0, 0, 0, 0};
        o = '0;
        o.pc_en   = 1'b1;
        o.ifid_en = 1'b1;
        if (mem_busy) begin
            o.pc_en       = 1'b0;
            o.ifid_en     = 1'b0;
            o.pipe_freeze = 1'b1;
        end else if (m.mode == 1 || (m.mode == 0 && hit)) begin
            o.pc_en       = 1'b0;
            o.ifid_en     = 1'b0;
            o.idex_bubble = 1'b1;
            m.stall_c++;
            if (m.mode == 0) m.left = load_lat - 1;
            else             m.left--;
            m.mode = (m.left > 0) ? 1 : 0;
        end else if (m.mode == 2 || (m.mode == 0 && redirect_id)) begin
            o.ifid_flush = 1'b1;
            m.flush_c++;
            if (m.mode == 0) m.left = flush_slots - 1;
            else             m.left--;
            m.mode = (m.left > 0) ? 2 : 0;
        end
        if (reset_0) m = '{0, 0, 0, 0};
        return o;
    endfunction

    task automatic compare_pop();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        check({e.tag, ".a_outs"}, 64'({a_pc_en, a_ifid_en, a_ifid_flush, a_idex_bubble, a_pipe_freeze}),
              64'(e.a_o));
        check({e.tag, ".b_outs"}, 64'({b_pc_en, b_ifid_en, b_ifid_flush, b_idex_bubble, b_pipe_freeze}),
              64'(e.b_o));
        check({e.tag, ".a_stall_cnt"}, 64'(a_stall_cnt), 64'(e.a_s));
        check({e.tag, ".a_flush_cnt"}, 64'(a_flush_cnt), 64'(e.a_f));
        check({e.tag, ".b_stall_cnt"}, 64'(b_stall_cnt), 64'(e.b_s));
        check({e.tag, ".b_flush_cnt"}, 64'(b_flush_cnt), 64'(e.b_f));
        if (a_idex_bubble) a_bubbles++;
        if (b_idex_bubble) b_bubbles++;
        if (b_ifid_flush)  b_flushes++;
    endtask

    task automatic cyc(input string tag, input bit mr, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input bit urs, input bit urt, input bit redir,
                       input bit busy);
        exp_t e;
        @(posedge clock);
        #1;
        ex_memread  = mr;
        ex_rd       = rd;
        rs_id       = rs;
        rt_id       = rt;
        use_rs_id   = urs;
        use_rt_id   = urt;
        redirect_id = redir;
        mem_busy    = busy;
        if (reset_0) begin
            ma = '{0, 0, 0, 0};
            mb = '{0, 0, 0, 0};
        end
        e.tag = tag;
        e.a_s = perf(ma.stall_c);
        e.a_f = perf(ma.flush_c);
        e.b_s = perf(mb.stall_c);
        e.b_f = perf(mb.flush_c);
        e.a_o = model_step(ma, 1, 1);
        e.b_o = model_step(mb, 3, 2);
        sb.push_back(e);
        @(negedge clock);
        compare_pop();
    endtask

    task automatic quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    endtask

    initial begin
        reset_0     = 1'b1;
        rs_id       = '0;
        rt_id       = '0;
        ex_rd       = '0;
        use_rs_id   = 1'b0;
        use_rt_id   = 1'b0;
        ex_memread  = 1'b0;
        redirect_id = 1'b0;
        mem_busy    = 1'b0;
        ma = '{0, 0, 0, 0};
        mb = '{0, 0, 0, 0};

        cyc("reset", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        reset_0 = 1'b0;
        quiet("idle", 2);

        // Single load-use hit on rs: 1 bubble on dut_a, 3 on dut_b.
        a_bubbles = 0;
        b_bubbles = 0;
        cyc("lu_rs", 1, 5'd8, 5'd8, 5'd3, 1, 0, 0, 0);
        quiet("lu_rs_after", 4);
        check("lu_rs.a_bubbles", 64'(a_bubbles), 64'd1);
        check("lu_rs.b_bubbles", 64'(b_bubbles), 64'd3);

        // ex_rd == 0 never stalls; rs match with use_rs_id low never stalls.
        cyc("lu_r0", 1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0);
        cyc("lu_unused", 1, 5'd9, 5'd9, 5'd2, 0, 0, 0, 0);
        cyc("lu_rt", 1, 5'd31, 5'd4, 5'd31, 0, 1, 0, 0);
        quiet("lu_rt_after", 3);

        // Redirect, then a load-use hit in the second slot (ignored by dut_b, stalls dut_a).
        b_flushes = 0;
        cyc("redir", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        cyc("redir_lu", 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0);
        quiet("redir_after", 4);
        check("redir.b_flushes", 64'(b_flushes), 64'd2);

        // Load-use hit and redirect together: load-use wins.
        cyc("lu_and_redir", 1, 5'd6, 5'd0, 5'd6, 0, 1, 1, 0);
        quiet("lu_and_redir_after", 4);

        // Memory freeze in the middle of dut_b's stall; the remaining bubbles still complete.
        b_bubbles = 0;
        cyc("frz_hit", 1, 5'd7, 5'd7, 5'd0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc("frz_busy", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
        quiet("frz_after", 4);
        check("frz.b_bubbles", 64'(b_bubbles), 64'd3);

        // Asynchronous reset during dut_b's stall abandons the sequence immediately.
        cyc("rst_hit", 1, 5'd10, 5'd10, 5'd0, 1, 0, 0, 0);
        @(posedge clock);
        #1;
        ex_memread = 1'b0;
        use_rs_id  = 1'b0;
        reset_0    = 1'b1;
        #1;
        check("rst_mid.b_pc_en", 64'(b_pc_en), 64'd1);
        check("rst_mid.b_idex_bubble", 64'(b_idex_bubble), 64'd0);
        check("rst_mid.b_stall_cnt", 64'(b_stall_cnt), 64'd0);
        check("rst_mid.b_flush_cnt", 64'(b_flush_cnt), 64'd0);
        check("rst_mid.a_stall_cnt", 64'(a_stall_cnt), 64'd0);
        #1;
        reset_0 = 1'b0;
        ma = '{0, 0, 0, 0};
        mb = '{0, 0, 0, 0};
        quiet("rst_after", 3);

        // Random mix over a small register range to provoke frequent hits.
        for (int i = 0; i < 400; i++) begin
            cyc("rand", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
        end
        quiet("drain", 4);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
